// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage: owns the fetch PC, issues in-order word reads to instruction
// memory, buffers returned words together with their addresses in a small
// FIFO and hands them to decode one per handshake. Redirects from execute
// (taken branch / jal) flush the buffer and discard responses still in flight.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   imem_req_*       read request channel (valid/ready, word address)
//   imem_resp_*      read response channel (in order, at least 1 cycle after req)
//   instr_valid/ready, instruction, pc_out
//                    output channel, FIFO head
//   redirect_valid, redirect_pc
//                    new fetch address from execute
//   misalign_err     1-cycle pulse after a redirect to a non-word-aligned target
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned              FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [DATA_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   imem_resp_data,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [DATA_WIDTH-1:0]   pc_out,
    input  logic                    redirect_valid,
    input  logic [DATA_WIDTH-1:0]   redirect_pc,
    output logic                    misalign_err
);

    // FIFO_DEPTH must be a power of two, at least 2.
    localparam int unsigned           AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned           CW      = AW + 1;
    localparam logic [CW:0]           DEPTH_X = (CW+1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DATA_WIDTH-1:0]  r_fetch_pc;
    logic [CW-1:0]          r_outstanding;
    logic [CW-1:0]          r_drop_cnt;
    logic [CW-1:0]          w_drop_nxt;
    logic                   r_misalign;

    // Issuing PC of every request still owed a response, oldest first.
    logic [DATA_WIDTH-1:0]  r_pcq [FIFO_DEPTH];
    logic [AW-1:0]          r_pcq_wr;
    logic [AW-1:0]          r_pcq_rd;

    // Output buffer: instruction word plus its address.
    logic [DATA_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  r_fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0]          r_fifo_wr;
    logic [AW-1:0]          r_fifo_rd;
    logic [CW-1:0]          r_fifo_cnt;

    logic                   w_redirect;
    logic                   w_req_fire;
    logic                   w_resp_accept;
    logic                   w_pop;
    logic [CW-1:0]          w_remaining;
    logic [CW:0]            w_occ_sum;

    // Redirects are ignored during the single IDLE cycle after reset.
    assign w_redirect    = redirect_valid && (r_state != S_IDLE);
    assign w_req_fire    = imem_req_valid && imem_req_ready;
    assign w_resp_accept = imem_resp_valid && (r_state == S_FETCH) && !w_redirect;
    assign w_pop         = instr_valid && instr_ready;

    // Words still owed by memory once this cycle's response (if any) lands.
    assign w_remaining   = r_outstanding - CW'(imem_resp_valid);

    // Requests in flight plus buffered words bound the space a response may need.
    assign w_occ_sum     = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_drop_nxt     = r_drop_cnt;
        imem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH, S_DRAIN: begin
                // A redirect restarts the drop count from whatever is still
                // in flight; DRAIN otherwise counts its responses down.
                if (w_redirect) begin
                    w_drop_nxt = w_remaining;
                end else if ((r_state == S_DRAIN) && imem_resp_valid) begin
                    w_drop_nxt = r_drop_cnt - CW'(1);
                end
                w_state_nxt    = (w_drop_nxt != '0) ? S_DRAIN : S_FETCH;
                imem_req_valid = (r_state == S_FETCH) && !redirect_valid &&
                                 (w_occ_sum < DEPTH_X);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // PC, counters, queue pointers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_misalign    <= 1'b0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
            r_fifo_cnt    <= '0;
        end else begin
            r_misalign    <= w_redirect && (redirect_pc[1:0] != 2'b00);
            r_drop_cnt    <= w_drop_nxt;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

            if (w_redirect) begin
                r_fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
            end

            if (w_redirect) begin
                // A pop in this cycle has already been delivered; flushing
                // discards only what would have remained.
                r_pcq_wr   <= '0;
                r_pcq_rd   <= '0;
                r_fifo_wr  <= '0;
                r_fifo_rd  <= '0;
                r_fifo_cnt <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pcq_wr <= r_pcq_wr + AW'(1);
                end
                if (w_resp_accept) begin
                    r_pcq_rd  <= r_pcq_rd + AW'(1);
                    r_fifo_wr <= r_fifo_wr + AW'(1);
                end
                if (w_pop) begin
                    r_fifo_rd <= r_fifo_rd + AW'(1);
                end
                case ({w_resp_accept, w_pop})
                    2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                    2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                    default: r_fifo_cnt <= r_fifo_cnt;
                endcase
            end
        end
    end

    // Storage arrays need no reset: pointers and counts qualify every read.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (w_resp_accept) begin
            r_fifo_data[r_fifo_wr] <= imem_resp_data;
            r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign imem_req_addr = r_fetch_pc;
    assign misalign_err  = r_misalign;
    assign instr_valid   = (r_fifo_cnt != '0);
    assign instruction   = instr_valid ? r_fifo_data[r_fifo_rd] : NOP;
    assign pc_out        = instr_valid ? r_fifo_pc[r_fifo_rd]   : RESET_PC;

    // Request gating guarantees space for every accepted response.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_resp_accept && !w_pop && (r_fifo_cnt == DEPTH_X[CW-1:0])));

    // Memory must never answer a request that was not issued.
    a_resp_owed: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (r_outstanding == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .pc_out          (pc_out),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .misalign_err    (misalign_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: memory-side request queue (with wrong-path
    // marks), words the fetch unit should be holding, next expected addresses.
    logic [31:0] mq_addr[$];
    bit          mq_stale[$];
    int          occ;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_out_pc;
    bit          exp_mis;
    bit          idle;
    int          cyc;
    int          first_req_cyc;
    int          first_iv_cyc;
    int          n_deliv;
    int          n_mis;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, check outputs, advance model.
    task automatic step(input bit mrdy, input bit ordy, input bit redir,
                        input logic [31:0] rpc, input bit resp_en);
        bit give, exp_iv, exp_rv, racc, s, stale;
        int good;
        cyc++;
        give            = resp_en && (mq_addr.size() > 0);
        imem_req_ready  = mrdy;
        instr_ready     = ordy;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_resp_valid = give;
        imem_resp_data  = give ? memfun(mq_addr[0]) : $urandom();
        #1;
        good  = 0;
        stale = 0;
        foreach (mq_stale[i]) begin
            if (mq_stale[i]) stale = 1;
            else good++;
        end
        racc   = redir && !idle;
        exp_iv = (occ > 0);
        exp_rv = !idle && !redir && !stale && ((good + occ) < DEPTH);

        check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
        if (exp_iv) begin
            check("pc_out", pc_out, exp_out_pc);
            check("instruction", instruction, memfun(exp_out_pc));
        end
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, exp_req_pc);

        if (imem_req_valid && imem_req_ready && first_req_cyc < 0) first_req_cyc = cyc;
        if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
        if (instr_valid && instr_ready) n_deliv++;
        if (misalign_err) n_mis++;

        if (exp_iv && ordy) begin
            occ--;
            exp_out_pc += 32'd4;
        end
        if (give) begin
            s = mq_stale.pop_front();
            void'(mq_addr.pop_front());
            if (!s && !racc) occ++;
        end
        if (exp_rv && mrdy) begin
            mq_addr.push_back(exp_req_pc);
            mq_stale.push_back(1'b0);
            exp_req_pc += 32'd4;
        end
        if (racc) begin
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            occ        = 0;
            exp_out_pc = {rpc[31:2], 2'b00};
            exp_req_pc = {rpc[31:2], 2'b00};
        end
        exp_mis = racc && (rpc[1:0] != 2'b00);
        idle    = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_req_ready  = 1'b0;
        instr_ready     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instruction", instruction, 32'h0000_0013);
        check("rst_pc_out", pc_out, RST_PC);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
        rst = 1'b0;
        mq_addr.delete();
        mq_stale.delete();
        occ           = 0;
        exp_req_pc    = RST_PC;
        exp_out_pc    = RST_PC;
        exp_mis       = 1'b0;
        idle          = 1'b1;
        first_req_cyc = -1;
        first_iv_cyc  = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] rp;
        cyc     = 0;
        n_deliv = 0;
        n_mis   = 0;

        // T1: free-running fetch from reset
        do_reset(2);
        repeat (12) step(1, 1, 0, 32'h0, 1);
        check("t1_first_req_seen", {31'b0, first_req_cyc >= 0}, 32'h1);
        check("t1_latency", first_iv_cyc - first_req_cyc, 32'd2);

        // T2: downstream stalls for 5 cycles
        repeat (5) step(1, 0, 0, 32'h0, 1);
        check("t2_held_valid", {31'b0, instr_valid}, 32'h1);
        check("t2_req_blocked", {31'b0, imem_req_valid}, 32'h0);
        repeat (6) step(1, 1, 0, 32'h0, 1);

        // T3: jal at pc 8 with two wrong-path words in flight
        do_reset(2);
        k = 0;
        while (exp_out_pc != 32'hC && k < 40) begin
            step(1, 1, 0, 32'h0, 1);
            k++;
        end
        k = 0;
        while (mq_addr.size() < 2 && k < 10) begin
            step(1, 1, 0, 32'h0, 0);
            k++;
        end
        step(1, 1, 1, 32'h40, 0);
        k = 0;
        do begin
            step(1, 1, 0, 32'h0, 1);
            k++;
        end while (!instr_valid && k < 20);
        check("t3_valid_after_drop", {31'b0, instr_valid}, 32'h1);
        check("t3_first_pc", pc_out, 32'h40);
        repeat (6) step(1, 1, 0, 32'h0, 1);

        // T4: misaligned redirect target
        n_mis = 0;
        step(1, 1, 1, 32'h42, 1);
        k = 0;
        do begin
            step(1, 1, 0, 32'h0, 1);
            k++;
        end while (!instr_valid && k < 20);
        check("t4_first_pc", pc_out, 32'h40);
        repeat (8) step(1, 1, 0, 32'h0, 1);
        check("t4_pulse_count", n_mis, 32'd1);

        // T5: address wrap, then reset in the middle of traffic
        step(1, 1, 1, 32'hFFFF_FFF8, 1);
        k = 0;
        do begin
            step(1, 1, 0, 32'h0, 1);
            k++;
        end while (!(instr_valid && pc_out == 32'h0) && k < 30);
        check("t5_wrap_pc", pc_out, 32'h0);
        check("t5_wrap_instr", instruction, memfun(32'h0));
        repeat (2) step(1, 1, 0, 32'h0, 0);
        do_reset(1);
        repeat (8) step(1, 1, 0, 32'h0, 1);

        // T6: random handshakes and redirects
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            rp = $urandom();
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, rp, $urandom_range(0, 2) != 0);
        end
        check("t6_progress", {31'b0, n_deliv > 200}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
